// File: rtl/perf_mon.sv
// rtl/perf_mon.sv - run-cycle / retire / event performance monitor with pass-flag snoop
// Ports: clk, rst_n (sync, active-low); start, clear (run control);
//   mem_we/mem_waddr/mem_wdata (data-memory write snoop); retire, evt[NUM_EVT], rd_sel (count sources / read select);
//   busy, done, pass, fail, timeout, cycles, retired, rd_cnt, fail_code (status and counters).
// Optional: define PERF_MON_EVT_EN to build the per-channel event counters and the rd_cnt mux.
module perf_mon #(
  parameter int                CNT_W       = 32,
  parameter int                NUM_EVT     = 4,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] PASS_ADDR   = 8'h08,
  parameter int                TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_waddr,
  input  logic [31:0]        mem_wdata,
  input  logic               retire,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [2:0]         rd_sel,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycles,
  output logic [CNT_W-1:0]   retired,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [31:0]        fail_code
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Last run cycle value before the edge that makes cycles reach TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t state_q, state_d;
  logic   term_wr;
  logic   tmo_hit;
  logic   run_clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // A flag-word write ends the run and beats a coincident timeout.
  assign term_wr = (state_q == RUN) && mem_we && (mem_waddr == PASS_ADDR);
  assign tmo_hit = (state_q == RUN) && (cycles == TO_LAST) && !term_wr;
  // Counters restart only when a run actually begins (start in RUN is ignored).
  assign run_clr = start && (state_q != RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (term_wr || tmo_hit) state_d = DONE;
        DONE:    if (start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear || run_clr) begin
      cycles    <= '0;
      retired   <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_code <= '0;
    end else if (state_q == RUN) begin
      cycles <= sat_inc(cycles);
      if (retire) retired <= sat_inc(retired);
      if (term_wr) begin
        if (mem_wdata == 32'd1) begin
          pass <= 1'b1;
        end else begin
          fail      <= 1'b1;
          fail_code <= mem_wdata;
        end
      end else if (tmo_hit) begin
        timeout <= 1'b1;
      end
    end
  end

`ifdef PERF_MON_EVT_EN
  logic [CNT_W-1:0] evt_cnt [NUM_EVT];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EVT; i++) begin
      if (!rst_n || clear || run_clr) evt_cnt[i] <= '0;
      else if (state_q == RUN && evt[i]) evt_cnt[i] <= sat_inc(evt_cnt[i]);
    end
  end

  // Selects beyond the populated channels fall through to zero.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (rd_sel == 3'(i)) rd_cnt = evt_cnt[i];
    end
  end
`else
  logic unused_evt;
  assign unused_evt = ^{evt, rd_sel};
  assign rd_cnt     = '0;
`endif

endmodule

// File: tb/tb_perf_mon.sv
// tb/tb_perf_mon.sv - directed self-checking bench for perf_mon
module tb_perf_mon;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear, mem_we, retire;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  evt;
  logic [2:0]  rd_sel;

  logic        a_busy, a_done, a_pass, a_fail, a_timeout;
  logic [31:0] a_cycles, a_retired, a_rd_cnt, a_fail_code;
  logic        b_busy, b_done, b_pass, b_fail, b_timeout;
  logic [3:0]  b_cycles, b_retired, b_rd_cnt;
  logic [31:0] b_fail_code;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  perf_mon #(.CNT_W(32), .NUM_EVT(4), .ADDR_W(8), .PASS_ADDR(8'h08), .TIMEOUT_CYC(20)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .retire(retire), .evt(evt), .rd_sel(rd_sel),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
    .cycles(a_cycles), .retired(a_retired), .rd_cnt(a_rd_cnt), .fail_code(a_fail_code)
  );

  perf_mon #(.CNT_W(4), .NUM_EVT(4), .ADDR_W(8), .PASS_ADDR(8'h08), .TIMEOUT_CYC(15)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .retire(retire), .evt(evt), .rd_sel(rd_sel),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
    .cycles(b_cycles), .retired(b_retired), .rd_cnt(b_rd_cnt), .fail_code(b_fail_code)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [7:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
    tick(1);
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [4:0] exp);
    check({tag, ".busy"},    a_busy,    exp[4]);
    check({tag, ".done"},    a_done,    exp[3]);
    check({tag, ".pass"},    a_pass,    exp[2]);
    check({tag, ".fail"},    a_fail,    exp[1]);
    check({tag, ".timeout"}, a_timeout, exp[0]);
  endtask

  logic [31:0] evt_exp [4];

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; mem_we = 1'b0;
    mem_waddr = '0; mem_wdata = '0; retire = 1'b0; evt = '0; rd_sel = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    check_flags("rst", 5'b00000);
    check("rst.cycles", a_cycles, 0);
    check("rst.retired", a_retired, 0);
    check("rst.fail_code", a_fail_code, 0);
    check("rst.rd_cnt", a_rd_cnt, 0);

    // Pass write in the 10th run cycle, retire every cycle
    begin_run();
    retire = 1'b1;
    tick(9);
    check_flags("p10.pre", 5'b10000);
    check("p10.pre.cycles", a_cycles, 9);
    write(8'h08, 32'd1);
    retire = 1'b0;
    check_flags("p10", 5'b01100);
    check("p10.cycles", a_cycles, 10);
    check("p10.retired", a_retired, 10);
    tick(3);
    check("p10.hold.cycles", a_cycles, 10);
    check_flags("p10.hold", 5'b01100);

    // Start in RUN ignored, other-address write ignored, then fail code
    begin_run();
    check("f.start.cycles", a_cycles, 0);
    check("f.start.pass", a_pass, 0);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("f.restart_ignored.cycles", a_cycles, 2);
    write(8'h0C, 32'd1);
    check_flags("f.other_addr", 5'b10000);
    write(8'h08, 32'hDEAD0003);
    check_flags("f", 5'b01010);
    check("f.fail_code", a_fail_code, 32'hDEAD0003);
    check("f.cycles", a_cycles, 4);

    // Writing zero to the flag word also fails
    begin_run();
    write(8'h08, 32'd0);
    check_flags("f0", 5'b01010);
    check("f0.fail_code", a_fail_code, 0);

    // Timeout at 20 run cycles
    begin_run();
    check("to.code_cleared", a_fail_code, 0);
    tick(19);
    check_flags("to.pre", 5'b10000);
    tick(1);
    check_flags("to", 5'b01001);
    check("to.cycles", a_cycles, 20);

    // Pass write on the timeout cycle: write wins
    begin_run();
    tick(19);
    write(8'h08, 32'd1);
    check_flags("pto", 5'b01100);
    check("pto.cycles", a_cycles, 20);

    // Event counters and rd_cnt mux
    begin_run();
    evt = 4'b0101;
    tick(7);
    evt = 4'b0000;
`ifdef PERF_MON_EVT_EN
    evt_exp[0] = 7; evt_exp[1] = 0; evt_exp[2] = 7; evt_exp[3] = 0;
`else
    evt_exp[0] = 0; evt_exp[1] = 0; evt_exp[2] = 0; evt_exp[3] = 0;
`endif
    rd_sel = 3'd0; #1 check("evt.sel0", a_rd_cnt, evt_exp[0]);
    rd_sel = 3'd1; #1 check("evt.sel1", a_rd_cnt, evt_exp[1]);
    rd_sel = 3'd2; #1 check("evt.sel2", a_rd_cnt, evt_exp[2]);
    rd_sel = 3'd3; #1 check("evt.sel3", a_rd_cnt, evt_exp[3]);
    rd_sel = 3'd5; #1 check("evt.sel5", a_rd_cnt, 0);
    rd_sel = 3'd0;

    // Clear mid-run beats a simultaneous start
    clear = 1'b1; start = 1'b1;
    tick(1);
    clear = 1'b0; start = 1'b0;
    check_flags("clr", 5'b00000);
    check("clr.cycles", a_cycles, 0);
    check("clr.rd_cnt", a_rd_cnt, 0);
    tick(2);
    check("clr.stays_idle", a_busy, 0);

    // Saturation on the 4-bit instance (15-cycle timeout)
    begin_run();
    retire = 1'b1;
    tick(30);
    retire = 1'b0;
    check("sat.retired", b_retired, 15);
    check("sat.cycles", b_cycles, 15);
    check("sat.timeout", b_timeout, 1);
    check("sat.done", b_done, 1);

    // Reset mid-run discards the run
    begin_run();
    retire = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    retire = 1'b0;
    check_flags("rstrun", 5'b00000);
    check("rstrun.cycles", a_cycles, 0);
    check("rstrun.retired", a_retired, 0);
    tick(3);
    check_flags("rstrun.idle", 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
